// File: rtl/aes_round_sequencer_if.sv
// Block-in / round-datapath / block-out signal bundle for the AES round sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface aes_round_sequencer_if #(
  parameter int IDXW = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    in_block;
  logic [IDXW-1:0] rk_idx;
  logic [127:0]    rk_in;
  logic [127:0]    rnd_state;
  logic [127:0]    rnd_key;
  logic            rnd_last;
  logic [127:0]    rnd_result;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    out_block;
  logic            busy;

  modport slave (
    input  in_valid, in_block, rk_in, rnd_result, out_ready,
    output in_ready, rk_idx, rnd_state, rnd_key, rnd_last, out_valid, out_block, busy
  );

  modport master (
    output in_valid, in_block, rk_in, rnd_result, out_ready,
    input  in_ready, rk_idx, rnd_state, rnd_key, rnd_last, out_valid, out_block, busy
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: owns the state register and round counter and
// drives an external combinational round datapath once per cycle for NR rounds.
module aes_round_sequencer #(
  parameter int NR   = 10,
  parameter int IDXW = 4
) (
  input logic clk,
  input logic rst,
  aes_round_sequencer_if.slave bus
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end
  if ((1 << IDXW) <= NR) begin : g_bad_idxw
    $error("aes_round_sequencer: IDXW too narrow to index NR round keys");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

  localparam logic [IDXW-1:0] LAST_ROUND = IDXW'(NR - 1);

  fsm_e            fsm_q, fsm_d;
  logic [127:0]    state_q, state_d;
  logic [IDXW-1:0] rnd_cnt_q, rnd_cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            rnd_last_q, rnd_last_d;

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_cnt_d = rnd_cnt_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d   = bus.in_block ^ bus.rk_in;
          rnd_cnt_d = IDXW'(1);
          fsm_d     = ROUND;
        end
      end
      ROUND: begin
        state_d   = bus.rnd_result;
        rnd_cnt_d = rnd_cnt_q + 1'b1;
        if (rnd_cnt_q == LAST_ROUND) fsm_d = FINAL;
      end
      FINAL: begin
        state_d = bus.rnd_result;
        fsm_d   = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          rnd_cnt_d = '0;
          fsm_d     = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // Outputs are registered by decoding the next state, so they align with fsm_q.
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
    rnd_last_d  = (fsm_d == FINAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rnd_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rnd_last_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_cnt_q   <= rnd_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rnd_last_q  <= rnd_last_d;
    end
  end

  // The counter already equals the key index in every state (0 idle, NR in FINAL/DONE).
  assign bus.rk_idx    = rnd_cnt_q;
  assign bus.rnd_state = state_q;
  assign bus.rnd_key   = bus.rk_in;
  assign bus.rnd_last  = rnd_last_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = state_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: NR=10 and NR=14 instances with a golden AES datapath
// and key store, a cycle-timeline model, and directed FIPS-197 / SP800-38A vectors.
module tb_aes_round_sequencer;

  localparam logic [255:0] K10 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K14 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_E  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_E  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT_C3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic         iv[2], ordy[2], rst_s[2];
  logic [127:0] ib[2];
  logic         ir[2], ov[2], bsy[2], lst[2];
  logic [3:0]   rki[2];
  logic [127:0] ob[2];
  logic [127:0] rk10[16], rk14[16];

  // ---------------- golden AES primitives ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, r, s, e;
    e = 8'd254;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (e[i]) inv = gmul(inv, x);
    end
    r = inv;
    s = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] b[16], t[16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w[60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 60; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [255:0] key, input int nk, input int nr,
                                           input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ round_key(key, nk, 0);
    for (int r = 1; r <= nr; r++) s = aes_round(s, round_key(key, nk, r), r == nr);
    return s;
  endfunction

  // ---------------- DUTs and environment ----------------
  aes_round_sequencer_if #(.IDXW(4)) if10 ();
  aes_round_sequencer_if #(.IDXW(4)) if14 ();

  assign if10.in_valid   = iv[0];
  assign if10.in_block   = ib[0];
  assign if10.out_ready  = ordy[0];
  assign if10.rk_in      = rk10[if10.rk_idx];
  assign if10.rnd_result = aes_round(if10.rnd_state, if10.rnd_key, if10.rnd_last);
  assign if14.in_valid   = iv[1];
  assign if14.in_block   = ib[1];
  assign if14.out_ready  = ordy[1];
  assign if14.rk_in      = rk14[if14.rk_idx];
  assign if14.rnd_result = aes_round(if14.rnd_state, if14.rnd_key, if14.rnd_last);

  assign ir[0] = if10.in_ready;  assign ir[1] = if14.in_ready;
  assign ov[0] = if10.out_valid; assign ov[1] = if14.out_valid;
  assign bsy[0] = if10.busy;     assign bsy[1] = if14.busy;
  assign lst[0] = if10.rnd_last; assign lst[1] = if14.rnd_last;
  assign rki[0] = if10.rk_idx;   assign rki[1] = if14.rk_idx;
  assign ob[0] = if10.out_block; assign ob[1] = if14.out_block;

  aes_round_sequencer #(.NR(10), .IDXW(4)) dut10 (.clk(clk), .rst(rst_s[0]), .bus(if10));
  aes_round_sequencer #(.NR(14), .IDXW(4)) dut14 (.clk(clk), .rst(rst_s[1]), .bus(if14));

  // ---------------- timeline model ----------------
  // t = edges since acceptance (-1 idle); rounds run t=0..NR-1, DONE at t=NR.
  int           t[2];
  logic [127:0] exp_ct[2];
  logic         chk_en = 1'b0;
  int           dut_acc[2], prev_acc[2], acc_n[2];
  logic         ov_prev[2];

  initial begin
    t[0] = -1; t[1] = -1;
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (rst_s[d]) t[d] = -1;
        else if (t[d] < 0) begin
          if (iv[d]) begin
            t[d] = 0;
            exp_ct[d] = (d == 0) ? encrypt(K10, 4, 10, ib[0]) : encrypt(K14, 8, 14, ib[1]);
          end
        end else if (t[d] < ((d == 0) ? 10 : 14)) t[d]++;
        else if (ordy[d]) t[d] = -1;
      end
    end
  end

  initial begin
    logic [7:0] e, g;
    int nr;
    acc_n[0] = 0; acc_n[1] = 0; dut_acc[0] = 0; dut_acc[1] = 0;
    prev_acc[0] = 0; prev_acc[1] = 0; ov_prev[0] = 1'b0; ov_prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          nr = (d == 0) ? 10 : 14;
          if (t[d] < 0)            e = 8'b1000_0000;
          else if (t[d] < nr - 1)  e = {4'b0100, 4'(t[d] + 1)};
          else if (t[d] == nr - 1) e = {4'b0101, 4'(nr)};
          else                     e = {4'b0110, 4'(nr)};
          g = {ir[d], bsy[d], ov[d], lst[d], rki[d]};
          checks++;
          if (g !== e) begin
            failures++;
            $display("FAIL ctrl[nr%0d] cyc=%0d {in_ready,busy,out_valid,rnd_last,rk_idx} got=%b want=%b",
                     nr, cyc, g, e);
          end
          if (t[d] == nr) begin
            checks++;
            if (ob[d] !== exp_ct[d]) begin
              failures++;
              $display("FAIL out_block[nr%0d] cyc=%0d got=%h want=%h", nr, cyc, ob[d], exp_ct[d]);
            end
          end
          if (ov[d] && !ov_prev[d]) begin
            checks++;
            if (cyc - dut_acc[d] != nr) begin
              failures++;
              $display("FAIL latency[nr%0d] got=%0d want=%0d", nr, cyc - dut_acc[d], nr);
            end
          end
          ov_prev[d] = ov[d];
          if (iv[d] && ir[d]) begin
            prev_acc[d] = dut_acc[d];
            dut_acc[d]  = cyc + 1;
            acc_n[d]++;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input int d, input logic [127:0] blk);
    ib[d] = blk;
    iv[d] = 1'b1;
    tick(1);
    iv[d] = 1'b0;
  endtask

  task automatic wait_ov(input int d, input string name);
    for (int k = 0; k < 40 && !ov[d]; k++) tick(1);
    check(name, 128'(ov[d]), 128'd1);
  endtask

  initial begin
    int n0, seen;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; rst_s[d] = 1'b1; ib[d] = '0;
    end
    for (int r = 0; r < 16; r++) begin
      rk10[r] = (r <= 10) ? round_key(K10, 4, r) : '0;
      rk14[r] = (r <= 14) ? round_key(K14, 8, r) : '0;
    end

    check("model_sbox53", 128'(sbox(8'h53)), 128'hed);
    check("model_rk10", round_key(K10, 4, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_fips_b", encrypt(K10, 4, 10, PT_B), CT_B);
    check("model_fips_c3", encrypt(K14, 8, 14, PT_C3), CT_C3);

    tick(2);
    chk_en = 1'b1;
    check("reset_out_block", ob[0], '0);
    check("reset_in_ready", 128'(ir[0]), 128'd1);
    check("reset_busy", 128'(bsy[0]), 128'd0);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    tick(1);

    // FIPS-197 App. B
    ordy[0] = 1'b1;
    send(0, PT_B);
    wait_ov(0, "fips_b_timeout");
    check("fips_b_ct", ob[0], CT_B);
    tick(1);

    // Backpressure in DONE
    ordy[0] = 1'b0;
    send(0, PT_E);
    wait_ov(0, "bp_timeout");
    for (int k = 0; k < 7; k++) begin
      check("bp_out_valid", 128'(ov[0]), 128'd1);
      check("bp_out_block", ob[0], CT_E);
      check("bp_in_ready", 128'(ir[0]), 128'd0);
      tick(1);
    end
    ordy[0] = 1'b1;
    tick(1);
    check("bp_release_in_ready", 128'(ir[0]), 128'd1);
    check("bp_release_out_valid", 128'(ov[0]), 128'd0);

    // Back-to-back with in_valid held through busy
    n0 = acc_n[0];
    ib[0] = PT_B;
    iv[0] = 1'b1;
    tick(1);
    ib[0] = PT_E;
    for (int k = 0; k < 40 && acc_n[0] < n0 + 2; k++) tick(1);
    tick(1);
    iv[0] = 1'b0;
    check("b2b_accepts", 128'(acc_n[0] - n0), 128'd2);
    check("b2b_interval", 128'(dut_acc[0] - prev_acc[0]), 128'd12);
    for (int k = 0; k < 40 && bsy[0]; k++) tick(1);
    check("b2b_idle", 128'(bsy[0]), 128'd0);

    // Reset mid-encryption at round 5
    send(0, PT_B);
    tick(4);
    rst_s[0] = 1'b1;
    tick(1);
    rst_s[0] = 1'b0;
    check("midrst_busy", 128'(bsy[0]), 128'd0);
    check("midrst_out_valid", 128'(ov[0]), 128'd0);
    check("midrst_state", ob[0], '0);
    send(0, PT_E);
    wait_ov(0, "midrst_timeout");
    check("midrst_next_ct", ob[0], CT_E);
    tick(1);

    // Reset during DONE with out_ready high
    send(0, PT_B);
    wait_ov(0, "donerst_timeout");
    rst_s[0] = 1'b1;
    tick(1);
    rst_s[0] = 1'b0;
    check("donerst_state", ob[0], '0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (ov[0]) seen++;
      tick(1);
    end
    check("donerst_no_out_valid", 128'(seen), 128'd0);

    // NR=14 build, FIPS-197 C.3
    ordy[1] = 1'b1;
    send(1, PT_C3);
    wait_ov(1, "c3_timeout");
    check("c3_ct", ob[1], CT_C3);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES-128/192/256 encryption controller. It owns the 128-bit state register and round counter, and sequences one external combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) once per cycle across NR rounds. Round keys come from the key-schedule store by index. It sits between the block-input interface and the output interface, with a valid/ready handshake on each side.

Parameters:
NR, 10, number of rounds; legal values 10, 12, 14; any other value is a synthesis error (generate-time check)
IDXW, 4, width of round-key index

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  plaintext block offered
in_ready  output  1  sequencer can accept block
in_block  input  128  plaintext, column-major, byte 0 in [127:120]
rk_idx  output  IDXW  round-key index requested
rk_in  input  128  round key for rk_idx, same cycle (combinational lookup)
rnd_state  output  128  state presented to round datapath (= state_reg)
rnd_key  output  128  key presented to round datapath (= rk_in)
rnd_last  output  1  final round: datapath bypasses MixColumns
rnd_result  input  128  combinational datapath output
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
out_block  output  128  ciphertext (= state_reg while out_valid)
busy  output  1  high in any state except IDLE

Behaviour:
- FSM states: IDLE, ROUND, FINAL, DONE. Registers: state_reg[127:0], rnd_cnt[IDXW-1:0].
- Reset (rst=1 at an edge): FSM=IDLE, state_reg=0, rnd_cnt=0. Resulting outputs: in_ready=1, out_valid=0, busy=0, rnd_last=0, rk_idx=0, out_block=0. Reset wins over every other event, including mid-encryption and during DONE. An in-flight block is discarded with no output.
- IDLE: in_ready=1, rk_idx=0. On in_valid & in_ready: state_reg <= in_block ^ rk_in (initial AddRoundKey, done in this block, not in the datapath); rnd_cnt <= 1. Next state is ROUND if NR>1 (always true).
- ROUND: rk_idx=rnd_cnt, rnd_last=0. Each cycle: state_reg <= rnd_result; rnd_cnt <= rnd_cnt+1. When rnd_cnt==NR-1, go to FINAL.
- FINAL: rk_idx=NR, rnd_last=1. state_reg <= rnd_result; go to DONE.
- DONE: out_valid=1, out_block=state_reg, in_ready=0. Hold state_reg and all outputs stable until out_ready=1. On out_valid & out_ready, go to IDLE and set rnd_cnt <= 0. No new block is accepted in the same cycle as output handoff.
- Latency: handshake accepted at edge E, out_valid high after edge E+NR (NR-1 ROUND cycles + 1 FINAL cycle). For NR=10, 10 cycles. Minimum issue interval is NR+2 cycles, with out_ready tied high.
- rnd_state is always state_reg. rnd_key is always rk_in. rk_idx in DONE is NR and is don't-care for the store.
- in_valid while not IDLE is ignored. No buffering, and in_block is not sampled.
- in_ready is a function of FSM state only. It has no combinational path from in_valid or out_ready.
- rnd_cnt never exceeds NR and never wraps.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, golden datapath + key store -> out_block=3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept; rk_idx sequence 0,1,...,10; rnd_last high only in the FINAL cycle.
- Backpressure: out_ready=0 for 7 cycles in DONE -> out_valid and out_block stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: two blocks offered continuously, out_ready=1 -> second accepted exactly NR+2 cycles after first; both ciphertexts correct; in_valid asserted during busy is ignored.
- Reset mid-operation: rst=1 at round 5 -> next cycle IDLE, state_reg=0, out_valid=0, busy=0; next block encrypts correctly.
- NR=14 build with FIPS-197 C.3 vector (key 000102...1f, plaintext 00112233445566778899aabbccddeeff) -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Reset asserted during DONE with out_ready=1 in the same cycle -> reset wins, no further out_valid.
